// File: rtl/otbn_rnd_edn_rsp.sv
// otbn_rnd_edn_rsp
//
// Entropy responder behind the OTBN RND special-purpose register. A core RND
// read (rnd_req_i, level) or prefetch (rnd_prefetch_i, pulse) starts an EDN
// fetch. EdnDataWidth/EdnWordWidth EDN words are packed, lowest word first,
// into one RND value. That value is held until the core consumes it with
// rnd_rd_i. EdnDataWidth must be a multiple of EdnWordWidth.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   rnd_req_i         core is stalled on an RND read
//   rnd_prefetch_i    start a fetch without consuming
//   rnd_rd_i          consume the buffered value
//   wipe_i            secure wipe of the buffer
//   rnd_valid_o       a complete value is buffered
//   rnd_data_o        packed value (zero unless complete)
//   rnd_fips_o        FIPS status of the buffered value
//   rnd_rd_err_o      one-cycle pulse: rnd_rd_i seen while not valid
//   edn_req_o         EDN request
//   edn_ack_i         EDN word acknowledge
//   edn_data_i        EDN word
//   edn_fips_i        EDN word FIPS flag
//
// Configuration macro: OTBN_RND_FIPS_TRACK_EN
//   defined   - rnd_fips_o is the AND of edn_fips_i over all words of the value
//   undefined - edn_fips_i is ignored and rnd_fips_o follows rnd_valid_o
module otbn_rnd_edn_rsp #(
  parameter int EdnDataWidth = 256,
  parameter int EdnWordWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rnd_req_i,
  input  logic                    rnd_prefetch_i,
  input  logic                    rnd_rd_i,
  input  logic                    wipe_i,
  output logic                    rnd_valid_o,
  output logic [EdnDataWidth-1:0] rnd_data_o,
  output logic                    rnd_fips_o,
  output logic                    rnd_rd_err_o,
  output logic                    edn_req_o,
  input  logic                    edn_ack_i,
  input  logic [EdnWordWidth-1:0] edn_data_i,
  input  logic                    edn_fips_i
);

  localparam int NumWords = EdnDataWidth / EdnWordWidth;
  localparam int CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumWords - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StFull  = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rd_err_q, rd_err_d;
  logic            word_we;   // accepted ack: store edn_data_i at word cnt_q
  logic            buf_clr;   // zero every buffer word
  logic            data_gate; // only a complete value is ever exposed

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Next-state logic. wipe_i outranks rnd_rd_i, which outranks a new fetch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_we  = 1'b0;
    buf_clr  = 1'b0;
    rd_err_d = rnd_rd_i && (state_q != StFull);
    unique case (state_q)
      StIdle: begin
        if (wipe_i) begin
          buf_clr = 1'b1;
          cnt_d   = '0;
        end else if (rnd_req_i || rnd_prefetch_i) begin
          state_d = StFetch;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        if (wipe_i) begin
          buf_clr = 1'b1;
          cnt_d   = '0;
          // A request may only be dropped after its ack. If the ack is
          // already here it is discarded and nothing is left to drain.
          state_d = edn_ack_i ? StIdle : StDrain;
        end else if (edn_ack_i) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (wipe_i) begin
          buf_clr = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (rnd_rd_i) begin
          buf_clr = 1'b1;
          cnt_d   = '0;
          state_d = rnd_prefetch_i ? StFetch : StIdle;
        end
      end
      StDrain: begin
        // Hold the request until the outstanding ack arrives, then drop it.
        if (edn_ack_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    rnd_valid_o  = (state_q == StFull);
    edn_req_o    = (state_q == StFetch) || (state_q == StDrain);
    rnd_rd_err_o = rd_err_q;
    data_gate    = (state_q == StFull);
  end

  // Packing buffer, one register per EDN word
  for (genvar gi = 0; gi < NumWords; gi++) begin : g_word
    logic [EdnWordWidth-1:0] word_q, word_d;

    always_comb begin
      word_d = word_q;
      if (buf_clr) begin
        word_d = '0;
      end else if (word_we && (cnt_q == CntW'(gi))) begin
        word_d = edn_data_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign rnd_data_o[gi*EdnWordWidth +: EdnWordWidth] = data_gate ? word_q : '0;
  end

`ifdef OTBN_RND_FIPS_TRACK_EN
  logic fips_q, fips_d;
  logic enter_fetch;

  assign enter_fetch = (state_d == StFetch) && (state_q != StFetch);

  // Accumulator starts optimistic on each fetch and drops on any non-FIPS word
  always_comb begin
    fips_d = fips_q;
    if (wipe_i) begin
      fips_d = 1'b0;
    end else if (enter_fetch) begin
      fips_d = 1'b1;
    end else if (word_we) begin
      fips_d = fips_q & edn_fips_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fips_q <= 1'b0;
    end else begin
      fips_q <= fips_d;
    end
  end

  assign rnd_fips_o = (state_q == StFull) && fips_q;
`else
  logic unused_edn_fips;
  assign unused_edn_fips = edn_fips_i;
  assign rnd_fips_o      = (state_q == StFull);
`endif

endmodule

// File: tb/tb_otbn_rnd_edn_rsp.sv
module tb_otbn_rnd_edn_rsp;

  localparam int W = 32;
  localparam int N = 8;
  localparam int D = W * N;
`ifdef OTBN_RND_FIPS_TRACK_EN
  localparam bit FipsTrack = 1'b1;
`else
  localparam bit FipsTrack = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_FULL  = 2;
  localparam int M_DRAIN = 3;

  localparam logic [D-1:0] Pattern1 =
    256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rnd_req = 1'b0;
  logic         rnd_prefetch = 1'b0;
  logic         rnd_rd = 1'b0;
  logic         wipe = 1'b0;
  logic         rnd_valid;
  logic [D-1:0] rnd_data;
  logic         rnd_fips;
  logic         rnd_rd_err;
  logic         edn_req;
  logic         edn_ack = 1'b0;
  logic [W-1:0] edn_data = '0;
  logic         edn_fips = 1'b0;

  always #5 clk = ~clk;

  otbn_rnd_edn_rsp #(.EdnDataWidth(D), .EdnWordWidth(W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rnd_req_i     (rnd_req),
    .rnd_prefetch_i(rnd_prefetch),
    .rnd_rd_i      (rnd_rd),
    .wipe_i        (wipe),
    .rnd_valid_o   (rnd_valid),
    .rnd_data_o    (rnd_data),
    .rnd_fips_o    (rnd_fips),
    .rnd_rd_err_o  (rnd_rd_err),
    .edn_req_o     (edn_req),
    .edn_ack_i     (edn_ack),
    .edn_data_i    (edn_data),
    .edn_fips_i    (edn_fips)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Behavioural model: words collected so far, plus the phase of the exchange
  int           m_mode = M_IDLE;
  logic [W-1:0] m_words[$];
  bit           m_fips = 1'b0;
  bit           m_err  = 1'b0;

  task automatic chk(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [D-1:0] m_data();
    logic [D-1:0] v;
    v = '0;
    if (m_mode == M_FULL) begin
      for (int i = 0; i < m_words.size(); i++) v[i*W +: W] = m_words[i];
    end
    return v;
  endfunction

  function automatic bit m_req();
    return (m_mode == M_FETCH) || (m_mode == M_DRAIN);
  endfunction

  // One clock edge of the reference behaviour, using the inputs the DUT sampled
  task automatic model_step();
    m_err = rnd_rd && (m_mode != M_FULL);
    case (m_mode)
      M_IDLE: begin
        if (wipe) begin
          m_words.delete(); m_fips = 1'b0;
        end else if (rnd_req || rnd_prefetch) begin
          m_mode = M_FETCH; m_words.delete(); m_fips = 1'b1;
        end
      end
      M_FETCH: begin
        if (wipe) begin
          m_words.delete(); m_fips = 1'b0;
          m_mode = edn_ack ? M_IDLE : M_DRAIN;
        end else if (edn_ack) begin
          m_words.push_back(edn_data);
          m_fips = m_fips & edn_fips;
          if (m_words.size() == N) m_mode = M_FULL;
        end
      end
      M_FULL: begin
        if (wipe) begin
          m_words.delete(); m_fips = 1'b0; m_mode = M_IDLE;
        end else if (rnd_rd) begin
          m_words.delete();
          if (rnd_prefetch) begin
            m_mode = M_FETCH; m_fips = 1'b1;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      default: begin
        if (edn_ack) m_mode = M_IDLE;
      end
    endcase
  endtask

  // Compare process: every cycle after reset, all outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid",   D'(rnd_valid),  D'(m_mode == M_FULL));
      chk("data",    rnd_data,       m_data());
      chk("fips",    D'(rnd_fips),   D'(FipsTrack ? ((m_mode == M_FULL) && m_fips) : (m_mode == M_FULL)));
      chk("edn_req", D'(edn_req),    D'(m_req()));
      chk("rd_err",  D'(rnd_rd_err), D'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc(input bit req, input bit pf, input bit rd, input bit wp,
                     input bit ack, input logic [W-1:0] d, input bit f);
    rnd_req = req; rnd_prefetch = pf; rnd_rd = rd; wipe = wp;
    edn_ack = ack; edn_data = d; edn_fips = f;
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    bit ack;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Reset state
    chk("rst_valid",   D'(rnd_valid),  '0);
    chk("rst_data",    rnd_data,       '0);
    chk("rst_fips",    D'(rnd_fips),   '0);
    chk("rst_rd_err",  D'(rnd_rd_err), '0);
    chk("rst_edn_req", D'(edn_req),    '0);
    chk_on = 1'b1;

    // Ack every cycle: request at cycle 0, value valid at cycle 9
    cyc(1, 0, 0, 0, 0, '0, 1);
    chk("t1_req_c1", D'(edn_req), D'(1'b1));
    for (int k = 0; k < N; k++) begin
      w = 32'(32'h11111111 * (k + 1));
      cyc(0, 0, 0, 0, 1, w, 1);
      if (k == N - 2) chk("t1_valid_c8", D'(rnd_valid), '0);
    end
    chk("t1_valid_c9", D'(rnd_valid), D'(1'b1));
    chk("t1_data", rnd_data, Pattern1);
    chk("t1_req_c9", D'(edn_req), '0);
    cyc(0, 0, 1, 0, 0, '0, 0);
    chk("t1_consumed", rnd_data, '0);

    // Acks with gaps
    cyc(1, 0, 0, 0, 0, '0, 1);
    for (int c = 1; c <= 20; c++) begin
      ack = (c == 2 || c == 5 || c == 6 || c == 9 || c == 10 || c == 14 || c == 15 || c == 20);
      cyc(0, 0, 0, 0, ack, $urandom, 1);
      if (c < 20) chk("t2_req_held", D'(edn_req), D'(1'b1));
      if (c == 19) chk("t2_valid_c20", D'(rnd_valid), '0);
    end
    chk("t2_valid_c21", D'(rnd_valid), D'(1'b1));
    cyc(0, 0, 1, 0, 0, '0, 0);

    // Prefetch, fill, then consume together with a new prefetch
    cyc(0, 1, 0, 0, 0, '0, 1);
    for (int k = 0; k < N; k++) cyc(0, 0, 0, 0, 1, $urandom, 1);
    chk("t3_valid", D'(rnd_valid), D'(1'b1));
    cyc(0, 1, 1, 0, 0, '0, 0);
    chk("t3_data_zero", rnd_data, '0);
    chk("t3_req_next", D'(edn_req), D'(1'b1));
    for (int k = 0; k < N; k++) begin
      cyc(0, 0, 0, 0, 1, $urandom, 1);
      if (k == N - 2) chk("t3_cnt_restart", D'(rnd_valid), '0);
    end
    chk("t3_refilled", D'(rnd_valid), D'(1'b1));
    cyc(0, 0, 1, 0, 0, '0, 0);

    // Wipe mid-fetch: request held until the outstanding ack, which is dropped
    cyc(1, 0, 0, 0, 0, '0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, $urandom, 1);
    cyc(0, 0, 0, 1, 0, '0, 1);
    chk("t4_drain_req", D'(edn_req), D'(1'b1));
    idle();
    idle();
    chk("t4_drain_hold", D'(edn_req), D'(1'b1));
    cyc(0, 0, 0, 0, 1, 32'hDEADBEEF, 1);
    chk("t4_req_drop", D'(edn_req), '0);
    chk("t4_data", rnd_data, '0);
    idle();
    chk("t4_idle", D'(edn_req), '0);

    // Ack and wipe together in Fetch: straight back to Idle
    cyc(1, 0, 0, 0, 0, '0, 1);
    cyc(0, 0, 0, 0, 1, $urandom, 1);
    cyc(0, 0, 0, 1, 1, $urandom, 1);
    chk("t4b_no_drain", D'(edn_req), '0);

    // Read while not valid
    cyc(0, 0, 1, 0, 0, '0, 0);
    chk("t5_err", D'(rnd_rd_err), D'(1'b1));
    chk("t5_req", D'(edn_req), '0);
    idle();
    chk("t5_err_pulse", D'(rnd_rd_err), '0);

    // FIPS tracking: word 4 is non-FIPS
    cyc(1, 0, 0, 0, 0, '0, 1);
    for (int k = 0; k < N; k++) cyc(0, 0, 0, 0, 1, $urandom, (k != 4));
    chk("t6_valid", D'(rnd_valid), D'(1'b1));
    chk("t6_fips", D'(rnd_fips), D'(FipsTrack ? 1'b0 : 1'b1));
    cyc(0, 0, 1, 0, 0, '0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ack = m_req() ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 10);
      cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
          ack, $urandom, $urandom_range(0, 99) < 90);
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
